// File: rtl/my_sub_pkg.sv
// my_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e        : controller states (IDLE, SHIFT, DONE)
//   WIDTH_DEFAULT  : default operand/result width
//   cnt_width()    : bit counter width for a given operand width
package my_sub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter only has to hold 0..w-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/my_full_subtractor.sv
// my_full_subtractor: combinational one-bit full subtractor (x - y - bin).
// Optional feature macro: SERIAL_SUB_POS_CHECK_EN adds the product-of-sums forms.
// Ports:
//   x_i, y_i, bin_i     : minuend bit, subtrahend bit, borrow in
//   d_o, bout_o         : difference and borrow out, sum-of-products form
//   d_pos_o, bout_pos_o : same results in product-of-sums form (macro only)
module my_full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
`ifdef SERIAL_SUB_POS_CHECK_EN
  output logic d_pos_o,
  output logic bout_pos_o,
`endif
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

`ifdef SERIAL_SUB_POS_CHECK_EN
  assign d_pos_o = (x_i | y_i | bin_i) & (x_i | ~y_i | ~bin_i) &
                   (~x_i | y_i | ~bin_i) & (~x_i | ~y_i | bin_i);
  // Borrow is 0 only for xyb in {000, 100, 101, 110}; minimal POS cover.
  assign bout_pos_o = (y_i | bin_i) & (~x_i | y_i) & (~x_i | bin_i);
`endif

endmodule

// File: rtl/my_serial_subtractor.sv
// my_serial_subtractor: bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH,
// LSB first, one bit per clock through a single full-subtractor cell.
// Optional feature macro: SERIAL_SUB_POS_CHECK_EN (SOP/POS cross-check flag).
// Ports:
//   clk_i, rst_i (sync, active high)
//   start_i, a_i, b_i   : request and operands, captured when start is accepted
//   busy_o              : high while bits are shifted
//   done_o              : one-cycle pulse, result valid
//   diff_o, borrow_out_o: result, held until the next accepted start
//   pos_mismatch_o      : sticky SOP/POS disagreement (macro only)
module my_serial_subtractor
  import my_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUB_POS_CHECK_EN
  output logic             pos_mismatch_o,
`endif
  output logic             borrow_out_o
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d, bo_q, bo_d;
  logic             busy_q, done_q;
  logic             cell_d, cell_bout, accept;

`ifdef SERIAL_SUB_POS_CHECK_EN
  logic cell_d_pos, cell_bout_pos, mis_q, mis_d;
`endif

  my_full_subtractor u_cell (
    .x_i        (a_sr_q[0]),
    .y_i        (b_sr_q[0]),
    .bin_i      (bor_q),
`ifdef SERIAL_SUB_POS_CHECK_EN
    .d_pos_o    (cell_d_pos),
    .bout_pos_o (cell_bout_pos),
`endif
    .d_o        (cell_d),
    .bout_o     (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    accept  = 1'b0;
`ifdef SERIAL_SUB_POS_CHECK_EN
    mis_d   = mis_q;
`endif

    case (state_q)
      IDLE:  accept = start_i;
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        bor_d  = cell_bout;
`ifdef SERIAL_SUB_POS_CHECK_EN
        if ((cell_d != cell_d_pos) || (cell_bout != cell_bout_pos)) mis_d = 1'b1;
`endif
        if (cnt_q == LAST) begin
          // Counter is left at LAST so it never wraps inside an operation.
          state_d = DONE;
          diff_d  = res_d;
          bo_d    = cell_bout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        accept  = start_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      a_sr_d  = a_i;
      b_sr_d  = b_i;
      res_d   = '0;
      bor_d   = 1'b0;
      cnt_d   = '0;
      diff_d  = '0;
      bo_d    = 1'b0;
`ifdef SERIAL_SUB_POS_CHECK_EN
      mis_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_POS_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
`ifdef SERIAL_SUB_POS_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign diff_o       = diff_q;
  assign borrow_out_o = bo_q;
`ifdef SERIAL_SUB_POS_CHECK_EN
  assign pos_mismatch_o = mis_q;
`endif

endmodule

// File: tb/tb_my_serial_subtractor.sv
module tb_my_serial_subtractor;

  localparam int W      = 8;
  localparam int N_RAND = 1000;
  localparam int BUDGET = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_POS_CHECK_EN
  logic         pos_mis;
`endif

  my_serial_subtractor #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .a_i            (a_in),
    .b_i            (b_in),
    .busy_o         (busy),
    .done_o         (done),
    .diff_o         (diff),
`ifdef SERIAL_SUB_POS_CHECK_EN
    .pos_mismatch_o (pos_mis),
`endif
    .borrow_out_o   (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done; returns edges waited and busy cycles observed.
  task automatic wait_done(input string nm, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < BUDGET) begin
      if (busy) nbusy++;
      step();
      n++;
    end
    chk({nm, "_timeout"}, 32'(done), 32'd1);
    chk({nm, "_busy_and_done"}, 32'(busy & done), 32'd0);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_diff"}, 32'(diff), 32'(e.d));
      chk({nm, "_borrow"}, 32'(borrow), 32'(e.bo));
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic ebo);
    int n, nb;
    exp_t e;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    step();
    e.d = ed;
    e.bo = ebo;
    sb.push_back(e);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    chk({nm, "_diff_cleared"}, 32'(diff), 32'd0);
    chk({nm, "_busy_on_accept"}, 32'(busy), 32'd1);
    wait_done(nm, n, nb);
    chk({nm, "_latency"}, 32'(n), 32'(W));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(W));
    pop_cmp(nm);
    step();
    chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({nm, "_diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int n, nb;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, bo: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'hFF, d: 8'h81, bo: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, bo: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bo: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h00, d: 8'h01, bo: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h80, d: 8'hFF, bo: 1'b1};

    // reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_POS_CHECK_EN
    chk("rst_pos_mismatch", 32'(pos_mis), 32'd0);
`endif
    rst = 1'b0;
    step();

    // table-driven vectors
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);

    // start held through SHIFT is ignored; start in DONE is accepted back-to-back
    start = 1'b1;
    a_in  = 8'h5A;
    b_in  = 8'h3C;
    step();
    sb.push_back('{d: 8'h1E, bo: 1'b0});
    a_in = 8'hFF;
    b_in = 8'h00;
    wait_done("b2b_first", n, nb);
    chk("b2b_first_latency", 32'(n), 32'(W));
    pop_cmp("b2b_first");
    a_in = 8'h10;
    b_in = 8'h01;
    step();
    sb.push_back('{d: 8'h0F, bo: 1'b0});
    start = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_accept_diff_cleared", 32'(diff), 32'd0);
    wait_done("b2b_second", n, nb);
    chk("b2b_second_gap", 32'(n + 1), 32'(W + 1));
    pop_cmp("b2b_second");
    step();
    chk("b2b_done_one_cycle", 32'(done), 32'd0);

    // reset during the 4th SHIFT cycle aborts
    start = 1'b1;
    a_in  = 8'hC3;
    b_in  = 8'h3C;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    n = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) n++;
      step();
    end
    chk("abort_no_done", 32'(n), 32'd0);
    run_op("after_abort", 8'h20, 8'h21, 8'hFF, 1'b1);

    // random operands against a - b model
    for (int i = 0; i < N_RAND; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, ra - rb, (ra < rb));
`ifdef SERIAL_SUB_POS_CHECK_EN
      chk("rand_pos_mismatch", 32'(pos_mis), 32'd0);
`endif
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_serial_subtractor.md
# my_serial_subtractor

Bit-serial unsigned subtractor computing A − B, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the subtracting counterpart of the team's half/full adder cells and reuses the same style of logic: the difference and borrow equations exist in both SOP and POS form. The block sits beside the adder cells as a small, area-cheap arithmetic unit with a start/done handshake, for use by sequential datapaths.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; operands are captured in the cycle start is accepted
- a  in  WIDTH  minuend, unsigned
- b  in  WIDTH  subtrahend, unsigned
- busy  out  1  high while bits are being shifted
- done  out  1  one-cycle pulse when the result is valid
- diff  out  WIDTH  (a − b) mod 2^WIDTH, held until next accepted start
- borrow_out  out  1  final borrow; 1 iff a < b (unsigned)
- pos_mismatch  out  1  only with SERIAL_SUB_POS_CHECK_EN; sticky SOP/POS disagreement flag

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → capture a, b into shift registers, clear borrow FF, clear bit counter, clear diff and borrow_out → SHIFT.
- SHIFT, every cycle: cell inputs are x = a_sr[0], y = b_sr[0], bin = borrow FF.
  - d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
  - d shifts into the MSB of the result register, which shifts right; a_sr and b_sr shift right; borrow FF ← bout; counter increments.
  - Counter reaching WIDTH−1 on this edge → DONE; diff ← final result register, borrow_out ← bout.
- DONE: done=1 for exactly one cycle. start=1 here is accepted with the same capture as in IDLE → SHIFT. Otherwise → IDLE.
- start is ignored while in SHIFT; a and b are don't-care outside the accepting cycle.
- The counter is $clog2(WIDTH) bits wide and never wraps within an operation.
- diff and borrow_out change only on entry to DONE, and clear when a new start is accepted.

## Timing
- Reset value: state IDLE; busy=0, done=0, diff=0, borrow_out=0, pos_mismatch=0; borrow FF, counter and shift registers all 0.
- Reset has priority over every other input. Reset during SHIFT aborts the operation: no done pulse, outputs are zero.
- If start is accepted at edge k: busy=1 after edges k..k+WIDTH−1; state is DONE after edge k+WIDTH; done and the result are visible in the cycle that follows.
- Latency from accepting start to done is WIDTH cycles. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy and done are never both high. All outputs are registered.

## Configuration
- SERIAL_SUB_POS_CHECK_EN defined:
  - The cell also computes the POS forms: d_pos = (x|y|bin)&(x|~y|~bin)&(~x|y|~bin)&(~x|~y|bin), and the borrow in POS form.
  - During SHIFT, any disagreement with the SOP outputs sets pos_mismatch.
  - pos_mismatch is sticky until rst, or until the next accepted start.
- Not defined: pos_mismatch port and POS logic are absent. Functional behaviour is otherwise identical.

## Structure
- Package my_sub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the default WIDTH constant
  - the counter-width function
- Sub-module my_full_subtractor is combinational: x, y, bin → d, bout, plus d_pos and bout_pos under the macro. It is instantiated once.

## Test plan
- a=8'h5A, b=8'h3C, start pulse → done exactly 8 cycles after acceptance; diff=8'h1E, borrow_out=0; busy high for 8 cycles.
- a=8'h00, b=8'h01 → diff=8'hFF, borrow_out=1. Also a=8'h80, b=8'hFF → diff=8'h81, borrow_out=1.
- a=b=8'hA5 → diff=8'h00, borrow_out=0. Also a=8'hFF, b=8'h00 → diff=8'hFF, borrow_out=0.
- Hold start high through SHIFT with different operands → ignored. Start in the DONE cycle with a=8'h10, b=8'h01 → second done WIDTH+1 cycles after the first, diff=8'h0F.
- rst asserted on the 4th SHIFT cycle → next cycle all outputs 0, state IDLE, no done. A subsequent start works normally.
- With the macro: random operands over 1000 operations → pos_mismatch stays 0; results match a − b.
